instr_sequencer: RTL and testbench

//  Fetch/cycle sequencer directly upstream of the CPU execute datapath (ALU, regs, RAM port).

---
 rtl/instr_sequencer_pkg.sv | 51 +++++
 rtl/cycle_length_decoder.sv | 12 +
 rtl/instr_sequencer.sv | 139 +++++++++++++
 tb/tb_instr_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared CPU sequencer types, opcode constants and the opcode -> tick-count table.
// Pure declarations and combinational helpers; no state.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_FETCH = 2'd0,
        SEQ_EXEC  = 2'd1,
        SEQ_HALT  = 2'd2,
        SEQ_INT   = 2'd3
    } seq_state_t;

    localparam logic [11:0] OP_HALT      = 12'hFF8;
    localparam logic [11:0] OP_SLP       = 12'hFF9;
    localparam logic [11:0] OP_NOP5      = 12'hFFB;
    localparam logic [11:0] OP_NOP7      = 12'hFFF;
    localparam logic [11:0] OP_RET       = 12'hFDF;
    localparam logic [11:0] OP_RETS     = 12'hFDE;
    localparam logic [11:0] OP_PSET      = 12'hE40;
    localparam logic [11:0] OP_PSET_MASK = 12'hFF0;

    localparam int CYCLES_SHORT = 5;
    localparam int CYCLES_STD   = 7;
    localparam int CYCLES_LONG  = 12;
    localparam int CYCLES_INT   = 12;

    // Anything not listed takes the common 7-tick timing.
    function automatic logic [3:0] cycle_len(input logic [11:0] op);
        logic [3:0] len;
        len = 4'(CYCLES_STD);
        casez (op)
            12'h0??:                  len = 4'(CYCLES_SHORT);
            12'h1??:                  len = 4'(CYCLES_LONG);
            12'hE4?:                  len = 4'(CYCLES_SHORT);
            12'hA8?:                  len = 4'(CYCLES_STD);
            OP_NOP5, OP_HALT, OP_SLP: len = 4'(CYCLES_SHORT);
            OP_NOP7, OP_RET:          len = 4'(CYCLES_STD);
            OP_RETS:                  len = 4'(CYCLES_LONG);
            default:                  len = 4'(CYCLES_STD);
        endcase
        return len;
    endfunction

    function automatic logic is_halt(input logic [11:0] op);
        return (op == OP_HALT) || (op == OP_SLP);
    endfunction

    function automatic logic is_pset(input logic [11:0] op);
        return (op & OP_PSET_MASK) == OP_PSET;
    endfunction

endpackage

// File: rtl/cycle_length_decoder.sv
// Opcode -> instruction length (5/7/12 ticks); purely combinational, zero latency.
// No flow control: the result follows the opcode input directly.
module cycle_length_decoder
    import instr_sequencer_pkg::*;
(
    input  logic [11:0] i_opcode,
    output logic [3:0]  o_len
);

    assign o_len = cycle_len(i_opcode);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/step sequencer feeding the execute datapath; one state step per clk_en tick, outputs registered.
// clk_en low freezes everything. Interrupt entry enabled by defining CPU_INTERRUPT_EN.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int          STEP_W   = 4,
    parameter logic [11:0] RESET_OP = 12'hFFB
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic [12:0]       pc,
    output logic [12:0]       rom_addr,
    input  logic [11:0]       rom_data,
    input  logic              irq_pending,
    input  logic              irq_enable,
    output logic [11:0]       opcode,
    output logic [STEP_W-1:0] step,
    output logic              exec_valid,
    output logic              last_step,
    output logic              int_entry,
    output logic              halted
);

    seq_state_t        r_state;
    logic [11:0]       r_opcode;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] r_last_idx;
    logic              r_exec_valid;
    logic              r_last_step;
    logic              r_int_entry;
    logic              r_halted;
    logic              r_inhibit;

    logic [3:0]        w_len;
    logic [STEP_W-1:0] w_step_nxt;
    logic              w_irq;

    cycle_length_decoder u_len_dec (
        .i_opcode (rom_data),
        .o_len    (w_len)
    );

`ifdef CPU_INTERRUPT_EN
    assign w_irq = irq_pending & irq_enable;
`else
    logic w_unused_irq;
    assign w_unused_irq = irq_pending | irq_enable;
    assign w_irq        = 1'b0;
`endif

    assign rom_addr   = pc;
    assign w_step_nxt = r_step + STEP_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= SEQ_FETCH;
            r_opcode     <= RESET_OP;
            r_step       <= '0;
            r_last_idx   <= '0;
            r_exec_valid <= 1'b0;
            r_last_step  <= 1'b0;
            r_int_entry  <= 1'b0;
            r_halted     <= 1'b0;
            r_inhibit    <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                SEQ_FETCH: begin
                    r_opcode     <= rom_data;
                    r_last_idx   <= STEP_W'(w_len - 4'd1);
                    r_step       <= STEP_W'(1);
                    r_exec_valid <= 1'b1;
                    r_state      <= SEQ_EXEC;
                    if (is_pset(rom_data)) begin
                        r_inhibit <= 1'b1;
                    end
                end
                SEQ_EXEC: begin
                    if (r_last_step) begin
                        r_last_step  <= 1'b0;
                        r_exec_valid <= 1'b0;
                        r_step       <= '0;
                        if (w_irq && !r_inhibit) begin
                            r_state     <= SEQ_INT;
                            r_int_entry <= 1'b1;
                        end else if (is_halt(r_opcode)) begin
                            r_state  <= SEQ_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= SEQ_FETCH;
                        end
                    end else begin
                        r_step <= w_step_nxt;
                        if (w_step_nxt == r_last_idx) begin
                            r_last_step <= 1'b1;
                            // A PSET keeps the shadow alive so it covers the instruction after it.
                            if (!is_pset(r_opcode)) begin
                                r_inhibit <= 1'b0;
                            end
                        end
                    end
                end
                SEQ_HALT: begin
                    if (w_irq) begin
                        r_state     <= SEQ_INT;
                        r_halted    <= 1'b0;
                        r_int_entry <= 1'b1;
                    end
                end
                SEQ_INT: begin
                    if (r_last_step) begin
                        r_last_step <= 1'b0;
                        r_int_entry <= 1'b0;
                        r_step      <= '0;
                        r_state     <= SEQ_FETCH;
                    end else begin
                        r_step <= w_step_nxt;
                        if (w_step_nxt == STEP_W'(CYCLES_INT - 1)) begin
                            r_last_step <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= SEQ_FETCH;
                    r_step  <= '0;
                end
            endcase
        end
    end

    assign opcode     = r_opcode;
    assign step       = r_step;
    assign exec_valid = r_exec_valid;
    assign last_step  = r_last_step;
    assign int_entry  = r_int_entry;
    assign halted     = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: instruction-length table plus clk_en, HALT, PSET and reset corner cases.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic [12:0] pc;
    logic [12:0] rom_addr;
    logic [11:0] rom_data;
    logic        irq_pending;
    logic        irq_enable;
    logic [11:0] opcode;
    logic [3:0]  step;
    logic        exec_valid;
    logic        last_step;
    logic        int_entry;
    logic        halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] op;
        int          len;
    } vec_t;

    vec_t vecs[10];

    instr_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_en      (clk_en),
        .pc          (pc),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .irq_pending (irq_pending),
        .irq_enable  (irq_enable),
        .opcode      (opcode),
        .step        (step),
        .exec_valid  (exec_valid),
        .last_step   (last_step),
        .int_entry   (int_entry),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge while the DUT sits in FETCH; returns at the negedge after the boundary.
    task automatic run_instr(input logic [11:0] op, input int exp_len);
        int   ticks;
        int   max_step;
        int   last_at;
        logic seen_last;
        logic int_seen;
        rom_data  = op;
        clk_en    = 1'b1;
        ticks     = 0;
        max_step  = 0;
        last_at   = -1;
        seen_last = 1'b0;
        int_seen  = 1'b0;
        do begin
            ticks++;
            if (int'(step) > max_step) max_step = int'(step);
            if (int_entry) int_seen = 1'b1;
            if (ticks == 2) begin
                check($sformatf("opcode_%03h", op), 32'(opcode), 32'(op));
                check($sformatf("exec_valid_%03h", op), 32'(exec_valid), 32'd1);
            end
            if (last_step) begin
                seen_last = 1'b1;
                last_at   = int'(step);
            end
            @(negedge clk);
        end while (!seen_last && ticks < 20);
        check($sformatf("ticks_%03h", op), 32'(ticks), 32'(exp_len));
        check($sformatf("last_at_%03h", op), 32'(last_at), 32'(exp_len - 1));
        check($sformatf("max_step_%03h", op), 32'(max_step), 32'(exp_len - 1));
        check($sformatf("no_int_%03h", op), 32'(int_seen), 32'd0);
        check($sformatf("boundary_step_%03h", op), 32'(step), 32'd0);
        check($sformatf("boundary_ev_%03h", op), 32'({exec_valid, last_step}), 32'd0);
    endtask

    // Called at the negedge where the INT sequence has just started (step 0).
    task automatic run_int(input string tag);
        int   ticks;
        int   last_at;
        logic seen_last;
        logic bad;
        ticks     = 0;
        last_at   = -1;
        seen_last = 1'b0;
        bad       = 1'b0;
        do begin
            ticks++;
            if (!int_entry || exec_valid || halted) bad = 1'b1;
            if (last_step) begin
                seen_last = 1'b1;
                last_at   = int'(step);
            end
            @(negedge clk);
        end while (!seen_last && ticks < 20);
        check({tag, "_int_ticks"}, 32'(ticks), 32'd12);
        check({tag, "_int_last_at"}, 32'(last_at), 32'd11);
        check({tag, "_int_flags"}, 32'(bad), 32'd0);
        check({tag, "_int_exit"}, 32'({int_entry, exec_valid, last_step, step}), 32'd0);
    endtask

    initial begin
        logic [19:0] snap;
        logic [19:0] cur;
        int          en_ticks;
        logic        hold_bad;
        logic        seen;
        logic        done;
        logic        lbad;

        vecs[0] = '{12'hA80, 7};
        vecs[1] = '{12'h0C3, 5};
        vecs[2] = '{12'h1AB, 12};
        vecs[3] = '{12'hFFB, 5};
        vecs[4] = '{12'hFFF, 7};
        vecs[5] = '{12'hFDF, 7};
        vecs[6] = '{12'hFDE, 12};
        vecs[7] = '{12'hE45, 5};
        vecs[8] = '{12'h5A5, 7};
        vecs[9] = '{12'hA8F, 7};

        reset_n     = 1'b0;
        clk_en      = 1'b0;
        pc          = 13'h1ABC;
        rom_data    = 12'hA80;
        irq_pending = 1'b0;
        irq_enable  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_opcode", 32'(opcode), 32'hFFB);
        check("rst_step", 32'(step), 32'd0);
        check("rst_flags", 32'({exec_valid, last_step, int_entry, halted}), 32'd0);
        check("rom_addr_a", 32'(rom_addr), 32'h1ABC);
        pc = 13'h0042;
        #1;
        check("rom_addr_b", 32'(rom_addr), 32'h0042);

        @(negedge clk);
        reset_n = 1'b1;
        clk_en  = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_instr(vecs[i].op, vecs[i].len);
        end

        // NOP7 with clk_en pulsed one cycle in four.
        rom_data = 12'hFFF;
        en_ticks = 0;
        hold_bad = 1'b0;
        seen     = 1'b0;
        done     = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            clk_en = (c % 4 == 0);
            snap = {opcode, step, exec_valid, last_step, int_entry, halted};
            @(negedge clk);
            cur = {opcode, step, exec_valid, last_step, int_entry, halted};
            if (!clk_en) begin
                if (cur !== snap) hold_bad = 1'b1;
            end else begin
                en_ticks++;
                if (seen) done = 1'b1;
                if (last_step) seen = 1'b1;
            end
        end
        clk_en = 1'b1;
        check("gated_ticks", 32'(en_ticks), 32'd7);
        check("gated_hold", 32'(hold_bad), 32'd0);
        check("gated_opcode", 32'(opcode), 32'hFFF);
        check("gated_exit", 32'({step, exec_valid, last_step}), 32'd0);

        // PSET shadow: the JP after it must run before any interrupt entry.
        irq_pending = 1'b1;
        irq_enable  = 1'b1;
        run_instr(12'hE40, 5);
        check("pset_no_int", 32'(int_entry), 32'd0);
        run_instr(12'h034, 5);
`ifdef CPU_INTERRUPT_EN
        check("jp_then_int", 32'(int_entry), 32'd1);
        irq_pending = 1'b0;
        run_int("pset");
`else
        check("jp_no_int", 32'(int_entry), 32'd0);
        irq_pending = 1'b0;
`endif
        irq_enable = 1'b0;

        // HALT idles with step 0 until woken.
        run_instr(12'hFF8, 5);
        check("halt_flag", 32'(halted), 32'd1);
        repeat (6) @(negedge clk);
        check("halt_hold", 32'({halted, step, int_entry}), 32'({1'b1, 4'd0, 1'b0}));
        irq_pending = 1'b1;
        irq_enable  = 1'b1;
`ifdef CPU_INTERRUPT_EN
        @(negedge clk);
        check("wake_int", 32'({int_entry, halted}), 32'b10);
        irq_pending = 1'b0;
        run_int("wake");
`else
        repeat (10) @(negedge clk);
        check("halt_ignores_irq", 32'({halted, int_entry}), 32'b10);
        irq_pending = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("halt_reset", 32'(halted), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
`endif
        irq_enable = 1'b0;
        check("post_halt_state", 32'({step, exec_valid, halted}), 32'd0);

        // Abort an ADD at step 3 with an asynchronous reset.
        rom_data = 12'hA80;
        for (int c = 0; c < 10 && step != 4'd3; c++) @(negedge clk);
        check("abort_at_step3", 32'(step), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("abort_opcode", 32'(opcode), 32'hFFB);
        check("abort_outputs", 32'({step, exec_valid, last_step, int_entry, halted}), 32'd0);
        lbad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (last_step || exec_valid) lbad = 1'b1;
        end
        check("abort_no_commit", 32'(lbad), 32'd0);
        reset_n = 1'b1;
        run_instr(12'hA80, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
